fft24_twiddle_mult: RTL and testbench
=====================================

Name: fft24_twiddle_mult

Overview:
- Inter-stage twiddle rotator for the 24-point DFT (24 = 4 x 6) in the PUSCH FFT chain.
- Consumes the stream produced by the radix-4 first stage, one sample per valid cycle, in order i = k1*6 + n2, with k1 = 0..3 and n2 = 0..5.
- Multiplies each sample by W24^(k1*n2). The twiddle comes from the existing 24-entry twiddle ROM, instantiated with its output register enabled.
- Output feeds the radix-6 second stage.

Parameters:
- DW, 16, signed data width of in/out real and imag parts
- TW_W, 18, twiddle width in Q10 format (1.0 = 1024); fixed by the ROM
- TW_FRAC, 10, fractional bits removed after the multiply

Ports:
- clk, input, 1, master clock, rising edge
- rst_n, input, 1, asynchronous active-low reset
- in_valid, input, 1, input sample valid
- in_sop, input, 1, first sample of a 24-sample block; qualified by in_valid
- in_re, input, DW, input real part, signed
- in_im, input, DW, input imag part, signed
- out_valid, output, 1, output sample valid
- out_sop, output, 1, output index 0 marker
- out_eop, output, 1, output index 23 marker
- out_re, output, DW, rotated real part, signed, saturated
- out_im, output, DW, rotated imag part, signed, saturated
- blk_err, output, 1, one-cycle pulse when in_sop arrives mid-block

Behaviour:
- Reset: clk and rst_n as named above. rst_n low asynchronously clears all pipeline valids, counters, outputs and blk_err to 0, and sets the FSM to IDLE. Reset asserted mid-block discards all in-flight samples; no output valid appears until a new in_sop.
- No backpressure: the downstream stage always accepts. in_valid may have gaps of any length; counters and the pipeline advance only on valid samples. Pipeline registers hold when no sample enters.
- FSM, two states:
  - IDLE: a sample with in_valid and no in_sop is dropped silently. in_valid & in_sop loads index 0, then moves to RUN.
  - RUN: each valid sample advances n2 from 0 to 5. When n2 wraps, k1 increments. The sample at index 23 (k1=3, n2=5) returns the FSM to IDLE, so every block requires its own in_sop.
  - in_valid & in_sop while in RUN with index != 0: restart at index 0 for this sample; blk_err pulses high on the next cycle. The partial block already in the pipeline is still output unchanged, but without out_eop.
- ROM address: addr = k1*n2 (range 0..15), computed combinationally from the counters for the current sample. The ROM's registered output lines up with pipeline stage 1.
- Pipeline, latency exactly 3 cycles from an in_valid edge to the matching out_valid edge:
  - S1: register the sample, sop/eop flags and valid; twiddle (c, d) arrives from the ROM.
  - S2: register the four signed products a*c, b*d, a*d, b*c, each DW+TW_W = 34 bits.
  - S3: re = a*c - b*d, im = a*d + b*c (35 bits each); add 512, arithmetic shift right by 10 (floor), saturate to [-32768, 32767]; register to the outputs.
- out_sop / out_eop mark index 0 / index 23 and are aligned with out_valid.
- When out_valid is 0, out_re and out_im hold their last value.

Decomposition:
- Package fft24_pkg holds: N=24, N1=4, N2=6, DW, TW_W, TW_FRAC, the round constant 512, and a function sat_dw(35-bit value) returning a DW-bit result.
- Sub-module cmul_q10: a 2-stage complex multiply with round and saturate, parameterised on DW and TW_W.
- Top level contains the FSM, the counters, ROM instance and the sop/eop/valid delay line.

Test Plan:
- Passthrough: in_sop, then (1000, 0) at index 1 (addr 0) -> out (1000, 0) exactly 3 cycles later, with out_sop low.
- Rotation: (1000, 0) at index 7 (k1=1, n2=1, addr 1, twiddle (989, -266)) -> out (966, -260).
- Rounding: (1024, 0) at index 23 (addr 15, twiddle (-725, 724)) -> out (-725, 724), with out_eop = 1.
- Saturation: (32767, 32767) at index 9 (addr 3, twiddle (724, -725)) -> out (32767, -32), saturated on the real part only.
- Gaps and framing:
  - Random in_valid gaps across a full block -> 24 outputs, each with correct value, in order, with one out_sop and one out_eop.
  - Valid samples before any sop -> no outputs.
  - in_sop at index 10 -> blk_err pulses once and indices restart from 0.
- Reset: assert rst_n low mid-block -> out_valid = 0 immediately and no stray outputs. A following sop block is processed correctly.

Source files
------------

// File: rtl/fft24_twiddle_mult_pkg.sv
// Shared constants and helpers for the 24-point DFT inter-stage twiddle rotator.
package fft24_pkg;

    localparam int N       = 24;
    localparam int N1      = 4;
    localparam int N2      = 6;
    localparam int DW      = 16;
    localparam int TW_W    = 18;
    localparam int TW_FRAC = 10;

    // Width of a full complex-product sum (one bit of growth over a single product).
    localparam int SW = DW + TW_W + 1;

    // Half an LSB of the Q10 result, added before the floor shift.
    localparam logic signed [SW-1:0] RND = 35'sd512;

    // Clamp a rounded, shifted sum into the signed DW-bit output range.
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [SW-1:0] v);
        if ((&v[SW-1:DW-1]) || !(|v[SW-1:DW-1])) begin
            return v[DW-1:0];
        end
        return v[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    endfunction

endpackage

// File: rtl/fft24_twiddle_mult_if.sv
// Sample stream between the radix-4 stage, the twiddle rotator and the radix-6 stage.
interface fft24_twiddle_mult_if #(
    parameter int DW = fft24_pkg::DW
);
    logic                 in_valid;
    logic                 in_sop;
    logic signed [DW-1:0] in_re;
    logic signed [DW-1:0] in_im;
    logic                 out_valid;
    logic                 out_sop;
    logic                 out_eop;
    logic signed [DW-1:0] out_re;
    logic signed [DW-1:0] out_im;
    logic                 blk_err;

    modport master (
        output in_valid, in_sop, in_re, in_im,
        input  out_valid, out_sop, out_eop, out_re, out_im, blk_err
    );

    modport slave (
        input  in_valid, in_sop, in_re, in_im,
        output out_valid, out_sop, out_eop, out_re, out_im, blk_err
    );
endinterface

// File: rtl/fft24_twiddle_mult_cmul.sv
// Two-stage complex multiply (a+jb)*(c+jd) with Q10 round-half-up and saturation.
module cmul_q10 #(
    parameter int DW      = 16,
    parameter int TW_W    = 18,
    parameter int TW_FRAC = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en1_i,
    input  logic                   en2_i,
    input  logic signed [DW-1:0]   a_i,
    input  logic signed [DW-1:0]   b_i,
    input  logic signed [TW_W-1:0] c_i,
    input  logic signed [TW_W-1:0] d_i,
    output logic signed [DW-1:0]   re_o,
    output logic signed [DW-1:0]   im_o
);
    import fft24_pkg::*;

    localparam int PW = DW + TW_W;
    localparam int XW = PW + 1;

    logic signed [PW-1:0] ac_q, bd_q, ad_q, bc_q;
    logic signed [XW-1:0] re_sum, im_sum, re_sh, im_sh;

    // Product stage: the four partial products, captured with the sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_q <= '0;
            bd_q <= '0;
            ad_q <= '0;
            bc_q <= '0;
        end else if (en1_i) begin
            ac_q <= PW'(a_i) * PW'(c_i);
            bd_q <= PW'(b_i) * PW'(d_i);
            ad_q <= PW'(a_i) * PW'(d_i);
            bc_q <= PW'(b_i) * PW'(c_i);
        end
    end

    // Combine, round half up, then floor-shift back to integer scale.
    always_comb begin
        re_sum = {ac_q[PW-1], ac_q} - {bd_q[PW-1], bd_q};
        im_sum = {ad_q[PW-1], ad_q} + {bc_q[PW-1], bc_q};
        re_sh  = (re_sum + RND) >>> TW_FRAC;
        im_sh  = (im_sum + RND) >>> TW_FRAC;
    end

    // Output stage: saturated result, held while no sample is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_o <= '0;
            im_o <= '0;
        end else if (en2_i) begin
            re_o <= sat_dw(re_sh);
            im_o <= sat_dw(im_sh);
        end
    end
endmodule

// File: rtl/fft24_twiddle_rom.sv
// 24-entry W24 twiddle ROM, Q10, with registered output.
// Entries are floor(1024*cos(2*pi*m/24)), floor(-1024*sin(2*pi*m/24)).
module fft24_twiddle_rom #(
    parameter int TW_W = 18
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic [4:0]             addr_i,
    output logic signed [TW_W-1:0] re_o,
    output logic signed [TW_W-1:0] im_o
);
    logic signed [TW_W-1:0] re_d, im_d;

    // Table lookup.
    always_comb begin
        re_d = '0;
        im_d = '0;
        case (addr_i)
            5'd0:  begin re_d = TW_W'(1024);  im_d = TW_W'(0);     end
            5'd1:  begin re_d = TW_W'(989);   im_d = TW_W'(-266);  end
            5'd2:  begin re_d = TW_W'(886);   im_d = TW_W'(-512);  end
            5'd3:  begin re_d = TW_W'(724);   im_d = TW_W'(-725);  end
            5'd4:  begin re_d = TW_W'(512);   im_d = TW_W'(-887);  end
            5'd5:  begin re_d = TW_W'(265);   im_d = TW_W'(-990);  end
            5'd6:  begin re_d = TW_W'(0);     im_d = TW_W'(-1024); end
            5'd7:  begin re_d = TW_W'(-266);  im_d = TW_W'(-990);  end
            5'd8:  begin re_d = TW_W'(-512);  im_d = TW_W'(-887);  end
            5'd9:  begin re_d = TW_W'(-725);  im_d = TW_W'(-725);  end
            5'd10: begin re_d = TW_W'(-887);  im_d = TW_W'(-512);  end
            5'd11: begin re_d = TW_W'(-990);  im_d = TW_W'(-266);  end
            5'd12: begin re_d = TW_W'(-1024); im_d = TW_W'(0);     end
            5'd13: begin re_d = TW_W'(-990);  im_d = TW_W'(265);   end
            5'd14: begin re_d = TW_W'(-887);  im_d = TW_W'(512);   end
            5'd15: begin re_d = TW_W'(-725);  im_d = TW_W'(724);   end
            5'd16: begin re_d = TW_W'(-512);  im_d = TW_W'(886);   end
            5'd17: begin re_d = TW_W'(-266);  im_d = TW_W'(989);   end
            5'd18: begin re_d = TW_W'(0);     im_d = TW_W'(1024);  end
            5'd19: begin re_d = TW_W'(265);   im_d = TW_W'(989);   end
            5'd20: begin re_d = TW_W'(512);   im_d = TW_W'(886);   end
            5'd21: begin re_d = TW_W'(724);   im_d = TW_W'(724);   end
            5'd22: begin re_d = TW_W'(886);   im_d = TW_W'(512);   end
            5'd23: begin re_d = TW_W'(989);   im_d = TW_W'(265);   end
            default: begin re_d = '0;         im_d = '0;           end
        endcase
    end

    // Output register, loaded only for accepted samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_o <= '0;
            im_o <= '0;
        end else if (en_i) begin
            re_o <= re_d;
            im_o <= im_d;
        end
    end
endmodule

// File: rtl/fft24_twiddle_mult.sv
// Inter-stage twiddle rotator for the 24 = 4 x 6 DFT: sample i = k1*6 + n2 is
// multiplied by W24^(k1*n2). Fixed 3-cycle latency, no backpressure.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for in_sop; valid samples without sop are dropped
//   ST_RUN   | inside a block; counters advance per valid sample
module fft24_twiddle_mult #(
    parameter int DW      = fft24_pkg::DW,
    parameter int TW_W    = fft24_pkg::TW_W,
    parameter int TW_FRAC = fft24_pkg::TW_FRAC
) (
    input logic                 clk,
    input logic                 rst_n,
    fft24_twiddle_mult_if.slave bus
);
    import fft24_pkg::*;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]             state_q, state_d;
    logic [1:0]             k1_q, k1_d, k1_cur;
    logic [2:0]             n2_q, n2_d, n2_cur;
    logic                   accept, last_cur, blk_err_d;
    logic [4:0]             rom_addr;
    logic signed [TW_W-1:0] tw_re, tw_im;
    logic signed [DW-1:0]   s1_re_q, s1_im_q, cm_re, cm_im;
    logic                   s1_valid_q, s1_sop_q, s1_eop_q;
    logic                   s2_valid_q, s2_sop_q, s2_eop_q;
    logic                   out_valid_q, out_sop_q, out_eop_q, blk_err_q;

    // Index of the current sample, acceptance and next FSM/counter state.
    // A sop always forces index 0, which also covers the mid-block restart.
    always_comb begin
        k1_cur    = bus.in_sop ? 2'd0 : k1_q;
        n2_cur    = bus.in_sop ? 3'd0 : n2_q;
        accept    = bus.in_valid && (bus.in_sop || (state_q == ST_RUN));
        last_cur  = (k1_cur == 2'(N1 - 1)) && (n2_cur == 3'(N2 - 1));
        rom_addr  = 5'(k1_cur) * 5'(n2_cur);
        blk_err_d = bus.in_valid && bus.in_sop && (state_q == ST_RUN);
        state_d   = state_q;
        k1_d      = k1_q;
        n2_d      = n2_q;
        if (accept) begin
            state_d = last_cur ? ST_IDLE : ST_RUN;
            if (n2_cur == 3'(N2 - 1)) begin
                n2_d = 3'd0;
                k1_d = k1_cur + 2'd1;
            end else begin
                n2_d = n2_cur + 3'd1;
                k1_d = k1_cur;
            end
        end
    end

    // FSM and index counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k1_q    <= '0;
            n2_q    <= '0;
        end else begin
            state_q <= state_d;
            k1_q    <= k1_d;
            n2_q    <= n2_d;
        end
    end

    // Stage 1: capture the accepted sample and its framing flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
        end else begin
            s1_valid_q <= accept;
            s1_sop_q   <= accept && bus.in_sop;
            s1_eop_q   <= accept && last_cur;
            if (accept) begin
                s1_re_q <= bus.in_re;
                s1_im_q <= bus.in_im;
            end
        end
    end

    // Flag delay line for stages 2 and 3, plus the restart error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_sop_q    <= 1'b0;
            s2_eop_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            blk_err_q   <= 1'b0;
        end else begin
            s2_valid_q  <= s1_valid_q;
            s2_sop_q    <= s1_sop_q;
            s2_eop_q    <= s1_eop_q;
            out_valid_q <= s2_valid_q;
            out_sop_q   <= s2_sop_q;
            out_eop_q   <= s2_eop_q;
            blk_err_q   <= blk_err_d;
        end
    end

    fft24_twiddle_rom #(.TW_W(TW_W)) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (accept),
        .addr_i (rom_addr),
        .re_o   (tw_re),
        .im_o   (tw_im)
    );

    cmul_q10 #(.DW(DW), .TW_W(TW_W), .TW_FRAC(TW_FRAC)) u_cmul (
        .clk   (clk),
        .rst_n (rst_n),
        .en1_i (s1_valid_q),
        .en2_i (s2_valid_q),
        .a_i   (s1_re_q),
        .b_i   (s1_im_q),
        .c_i   (tw_re),
        .d_i   (tw_im),
        .re_o  (cm_re),
        .im_o  (cm_im)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign bus.out_re    = cm_re;
    assign bus.out_im    = cm_im;
    assign bus.blk_err   = blk_err_q;
endmodule

// File: tb/tb_fft24_twiddle_mult.sv
// Randomised bench for fft24_twiddle_mult with a trigonometric reference model.
module tb_fft24_twiddle_mult;

    localparam real PI = 3.14159265358979323846;

    typedef struct {
        longint re;
        longint im;
        bit     sop;
        bit     eop;
        longint cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;

    exp_t   expq[$];
    longint err_q[$];
    exp_t   mon_e;
    bit     mon_err;
    bit     m_run = 1'b0;
    int     m_next = 0;

    fft24_twiddle_mult_if #(.DW(16)) bus ();

    fft24_twiddle_mult dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // W24^m in Q10, truncated toward minus infinity.
    function automatic longint tw_c(int m);
        return longint'($floor(1024.0 * $cos(2.0 * PI * m / 24.0) + 1.0e-6));
    endfunction

    function automatic longint tw_d(int m);
        return longint'($floor(-1024.0 * $sin(2.0 * PI * m / 24.0) + 1.0e-6));
    endfunction

    function automatic longint rnd_sat(longint v);
        longint t;
        t = (v + 512) >>> 10;
        if (t > 32767)  t = 32767;
        if (t < -32768) t = -32768;
        return t;
    endfunction

    function automatic int rnd16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return int'(v);
    endfunction

    // Reference behaviour for one valid input sample.
    task automatic model_step(bit sop, int a, int b);
        int     idx, m;
        longint c, d;
        if (sop) begin
            if (m_run) err_q.push_back(cyc + 1);
            idx = 0;
        end else if (m_run) begin
            idx = m_next;
        end else begin
            return;
        end
        m_next = idx + 1;
        m_run  = (idx != 23);
        m = (idx / 6) * (idx % 6);
        c = tw_c(m);
        d = tw_d(m);
        expq.push_back('{rnd_sat(longint'(a) * c - longint'(b) * d),
                         rnd_sat(longint'(a) * d + longint'(b) * c),
                         idx == 0, idx == 23, cyc});
    endtask

    task automatic send(bit sop, int a, int b);
        bus.in_valid = 1'b1;
        bus.in_sop   = sop;
        bus.in_re    = 16'(a);
        bus.in_im    = 16'(b);
        model_step(sop, a, b);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
    endtask

    task automatic gap(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_block(int start_idx, int max_gap);
        for (int i = start_idx; i < 24; i++) begin
            send(i == start_idx, rnd16(), rnd16());
            gap($urandom_range(0, max_gap));
        end
    endtask

    task automatic drain(string tag);
        int n;
        n = 0;
        while ((expq.size() != 0 || err_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        gap(4);
        check({tag, "_pending_out"}, expq.size(), 0);
        check({tag, "_pending_err"}, err_q.size(), 0);
    endtask

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                if (expq.size() == 0) begin
                    check("stray_out_valid", 1, 0);
                end else begin
                    mon_e = expq.pop_front();
                    check("out_re", bus.out_re, mon_e.re);
                    check("out_im", bus.out_im, mon_e.im);
                    check("out_sop", bus.out_sop, mon_e.sop);
                    check("out_eop", bus.out_eop, mon_e.eop);
                    check("latency", cyc - mon_e.cyc, 3);
                end
            end
            mon_err = (err_q.size() != 0) && (err_q[0] == cyc);
            if (bus.blk_err || mon_err) begin
                check("blk_err", bus.blk_err, mon_err);
                if (mon_err) void'(err_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_re    = '0;
        bus.in_im    = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_re", bus.out_re, 0);
        check("rst_out_im", bus.out_im, 0);
        check("rst_blk_err", bus.blk_err, 0);
        rst_n = 1'b1;
        gap(2);

        // Directed block: passthrough, rotation, saturation, rounding at eop.
        for (int i = 0; i < 24; i++) begin
            case (i)
                1:       send(1'b0, 1000, 0);
                7:       send(1'b0, 1000, 0);
                9:       send(1'b0, 32767, 32767);
                23:      send(1'b0, 1024, 0);
                default: send(i == 0, rnd16(), rnd16());
            endcase
        end
        drain("directed");

        // Samples with no sop after a completed block are dropped.
        for (int i = 0; i < 6; i++) send(1'b0, rnd16(), rnd16());
        drain("no_sop");

        // Full blocks with random valid gaps.
        for (int b = 0; b < 3; b++) send_block(0, 3);
        drain("gaps");

        // Restart with sop at index 10.
        for (int i = 0; i < 10; i++) send(i == 0, rnd16(), rnd16());
        send_block(0, 1);
        drain("restart");

        // Reset in the middle of a block with samples in flight.
        for (int i = 0; i < 9; i++) send(i == 0, rnd16(), rnd16());
        #2;
        rst_n = 1'b0;
        expq.delete();
        err_q.delete();
        m_run = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_blk_err", bus.blk_err, 0);
        gap(2);
        rst_n = 1'b1;
        gap(1);
        for (int i = 0; i < 4; i++) send(1'b0, rnd16(), rnd16());
        send_block(0, 2);
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
